ckgate_ctrl: RTL and testbench
==============================

// Module: ckgate_ctrl
// PURPOSE
//  Sequencer for the CKGATE enable pin. Shares one gated clock domain among NREQ
//  requesters and wakes the clock on any request. Reports clock-stable via RDY after
//  a programmable settle time. Gates the clock off after a programmable idle timeout.
//  Drives E/TE of a CKGATE instance; sits in the always-on domain clocked by CK.
// PARAMETERS
//  NREQ      4    number of requesters (>=1)
//  WAKE_CYC  2    CK cycles from E rise to RDY rise (>=1)
//  IDLE_CYC  16   CK cycles of no request before E falls (>=1)
//  CNT_W     8    width of internal down-counter; must hold max(WAKE_CYC,IDLE_CYC)-1
// PORTS
//  CK        in   1     free-running clock, all state on rising edge
//  RST       in   1     asynchronous reset, active high
//  TE_IN     in   1     scan/test enable from test controller
//  REQ       in   NREQ  per-requester clock request, level, active high
//  E         out  1     to CKGATE.E, registered
//  TE        out  1     to CKGATE.TE, = TE_IN (combinational passthrough)
//  RDY       out  1     gated clock running and settled, registered
//  STATE     out  2     FSM state: 0 OFF, 1 WAKE, 2 ON, 3 IDLE
// BEHAVIOUR
//  Reset (async, RST=1): STATE=OFF, E=0, RDY=0, counter=0; all stat outputs 0.
//  any_req = |REQ, sampled on CK rise. E=1 in WAKE/ON/IDLE, RDY=1 in ON/IDLE (both registered state decodes).
//  OFF : any_req -> WAKE, cnt<=WAKE_CYC-1. Else stay.
//  WAKE: cnt!=0 -> cnt-1. cnt==0 -> ON. REQ drop in WAKE does not abort; wake completes.
//  ON  : !any_req -> IDLE, cnt<=IDLE_CYC-1. Else stay.
//  IDLE: any_req -> ON (no re-wake, RDY stays 1). cnt==0 -> OFF. Else cnt-1.
//  Timing: REQ first seen at edge k -> E=1 from k, RDY=1 from k+WAKE_CYC.
//   All REQ low first seen at edge m (in ON) -> E=0, RDY=0 from m+IDLE_CYC, if no REQ returns.
//  Simultaneous: request arriving on the same edge IDLE cnt hits 0 -> ON wins (no gating).
//  TE_IN=1: TE=1 clocks target regardless of E. FSM runs unchanged. RDY is additionally forced 1 (RDY_out = RDY_reg | TE_IN).
//  RST asserted mid-WAKE/ON/IDLE: E and RDY drop immediately (async). Requesters must tolerate a clock stop.
//  No glitch on E: single flop output; CKGATE latch handles phase.
// CONFIGURATION
//  Macro CKGATE_CTRL_STATS_EN adds:
//   STAT_CLR  in  1   synchronous clear of both counters; clear beats increment
//   ON_CYC    out 32  cycles with E=1; saturates at 32'hFFFF_FFFF
//   WAKE_CNT  out 16  OFF->WAKE transitions; saturates at 16'hFFFF
//  Without macro: ports, counters and logic absent; core FSM identical.
// TESTING
//  1 Reset: RST=1 mid-ON -> E=0,RDY=0,STATE=0 same cycle; hold 0 after release with REQ=0.
//  2 Wake: defaults, REQ=4'b0001 at edge 10 -> E=1 from 10, RDY=1 from 12, STATE 1 then 2.
//  3 Idle timeout: REQ to 0 at edge 20 -> STATE=3 from 20, E=0/RDY=0 from edge 36, STATE=0.
//  4 Re-request: in IDLE, REQ=4'b0100 on edge where cnt==0 -> STATE=2, E never drops, RDY stays 1.
//  5 Test mode: TE_IN=1 with REQ=0 -> TE=1, RDY=1, E=0, STATE=0. TE_IN=0 -> RDY=0.
//  6 STATS_EN: two wake/idle cycles of 5 ON cycles -> WAKE_CNT=2. STAT_CLR during ON -> ON_CYC=0 next cycle, then counts.

Source files
------------

// File: rtl/ckgate_ctrl.sv
// Enable sequencer for a CKGATE cell: wakes the gated clock on any request, reports RDY after a settle
// time, and gates it off after an idle timeout. Optional statistics counters behind CKGATE_CTRL_STATS_EN.
module ckgate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            TE_IN,
  input  logic [NREQ-1:0] REQ,
`ifdef CKGATE_CTRL_STATS_EN
  input  logic            STAT_CLR,
  output logic [31:0]     ON_CYC,
  output logic [15:0]     WAKE_CNT,
`endif
  output logic            E,
  output logic            TE,
  output logic            RDY,
  output logic [1:0]      STATE
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             e_q;
  logic             rdy_q;
  logic             any_req;

  assign any_req = |REQ;

  // Valid/ready-style handshake: REQ is a level request; RDY high means the gated clock is settled.
  // E and RDY are registered alongside the state so each is a single glitch-free flop output.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (any_req) begin
            state_q <= ST_WAKE;
            cnt_q   <= WAKE_LD;
            e_q     <= 1'b1;
          end
        end
        ST_WAKE: begin
          // A request dropping mid-wake does not abort; the wake always completes.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_ON;
            rdy_q   <= 1'b1;
          end
        end
        ST_ON: begin
          if (!any_req) begin
            state_q <= ST_IDLE;
            cnt_q   <= IDLE_LD;
          end
        end
        ST_IDLE: begin
          // A request on the timeout edge wins: the clock is never gated off.
          if (any_req) begin
            state_q <= ST_ON;
          end else if (cnt_q == '0) begin
            state_q <= ST_OFF;
            e_q     <= 1'b0;
            rdy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_OFF;
          e_q     <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign E     = e_q;
  assign TE    = TE_IN;
  assign RDY   = rdy_q | TE_IN;
  assign STATE = state_q;

`ifdef CKGATE_CTRL_STATS_EN
  logic [31:0] on_cyc_q;
  logic [15:0] wake_cnt_q;
  logic        wake_evt;

  assign wake_evt = (state_q == ST_OFF) && any_req;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      on_cyc_q   <= '0;
      wake_cnt_q <= '0;
    end else if (STAT_CLR) begin
      on_cyc_q   <= '0;
      wake_cnt_q <= '0;
    end else begin
      if (e_q && (on_cyc_q != '1)) on_cyc_q <= on_cyc_q + 32'd1;
      if (wake_evt && (wake_cnt_q != '1)) wake_cnt_q <= wake_cnt_q + 16'd1;
    end
  end

  assign ON_CYC   = on_cyc_q;
  assign WAKE_CNT = wake_cnt_q;
`endif

endmodule

// File: tb/tb_ckgate_ctrl.sv
// Directed bench for ckgate_ctrl with default parameters (WAKE_CYC=2, IDLE_CYC=16).
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
module tb_ckgate_ctrl;

  logic       CK;
  logic       RST;
  logic       TE_IN;
  logic [3:0] REQ;
  logic       E;
  logic       TE;
  logic       RDY;
  logic [1:0] STATE;
`ifdef CKGATE_CTRL_STATS_EN
  logic        STAT_CLR;
  logic [31:0] ON_CYC;
  logic [15:0] WAKE_CNT;
`endif

  int errors;
  int checks;

  ckgate_ctrl dut (
    .CK       (CK),
    .RST      (RST),
    .TE_IN    (TE_IN),
    .REQ      (REQ),
`ifdef CKGATE_CTRL_STATS_EN
    .STAT_CLR (STAT_CLR),
    .ON_CYC   (ON_CYC),
    .WAKE_CNT (WAKE_CNT),
`endif
    .E        (E),
    .TE       (TE),
    .RDY      (RDY),
    .STATE    (STATE)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    // Reset state while RST is held
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", STATE); end
    checks++; if (E !== 1'b0) begin errors++; $display("FAIL rst_e got=%0b exp=0", E); end
    checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL rst_rdy got=%0b exp=0", RDY); end
    RST = 1'b0;
    // Bring the domain up to ON, then assert reset mid-cycle
    REQ = 4'b0010;
    repeat (3) step();
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL rst_pre_on got=%0d exp=2", STATE); end
    #2 RST = 1'b1;
    #1;
    checks++; if (E !== 1'b0) begin errors++; $display("FAIL rst_async_e got=%0b exp=0", E); end
    checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL rst_async_rdy got=%0b exp=0", RDY); end
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rst_async_state got=%0d exp=0", STATE); end
    REQ = 4'b0000;
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (E !== 1'b0 || RDY !== 1'b0 || STATE !== 2'd0) begin
        errors++; $display("FAIL rst_hold cyc=%0d got E=%0b RDY=%0b ST=%0d exp 0/0/0", i, E, RDY, STATE);
      end
    end
  endtask

  task automatic test_wake();
    REQ = 4'b0001;
    step();  // edge k
    checks++; if (E !== 1'b1) begin errors++; $display("FAIL wake_e_k got=%0b exp=1", E); end
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL wake_state_k got=%0d exp=1", STATE); end
    checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL wake_rdy_k got=%0b exp=0", RDY); end
    step();  // edge k+1
    checks++; if (RDY !== 1'b0 || STATE !== 2'd1) begin errors++; $display("FAIL wake_k1 got RDY=%0b ST=%0d exp 0/1", RDY, STATE); end
    step();  // edge k+2
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL wake_rdy_k2 got=%0b exp=1", RDY); end
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL wake_state_k2 got=%0d exp=2", STATE); end
    step();
  endtask

  task automatic test_idle_timeout();
    REQ = 4'b0000;
    step();  // edge m
    checks++; if (STATE !== 2'd3 || E !== 1'b1 || RDY !== 1'b1) begin
      errors++; $display("FAIL idle_enter got ST=%0d E=%0b RDY=%0b exp 3/1/1", STATE, E, RDY);
    end
    repeat (15) step();  // edge m+15
    checks++; if (STATE !== 2'd3 || E !== 1'b1) begin
      errors++; $display("FAIL idle_m15 got ST=%0d E=%0b exp 3/1", STATE, E);
    end
    step();  // edge m+16
    checks++; if (E !== 1'b0 || RDY !== 1'b0 || STATE !== 2'd0) begin
      errors++; $display("FAIL idle_off got ST=%0d E=%0b RDY=%0b exp 0/0/0", STATE, E, RDY);
    end
  endtask

  task automatic test_rerequest();
    int drops;
    drops = 0;
    REQ = 4'b1000;
    repeat (4) step();
    REQ = 4'b0000;
    step();  // IDLE entered, cnt=15
    for (int i = 0; i < 15; i++) begin
      step();
      if (E !== 1'b1 || RDY !== 1'b1) drops++;
    end
    checks++; if (drops !== 0) begin errors++; $display("FAIL rereq_hold got drops=%0d exp=0", drops); end
    REQ = 4'b0100;  // arrives on the edge where cnt==0
    step();
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL rereq_state got=%0d exp=2", STATE); end
    checks++; if (E !== 1'b1 || RDY !== 1'b1) begin errors++; $display("FAIL rereq_erdy got E=%0b RDY=%0b exp 1/1", E, RDY); end
    // Early re-request inside IDLE also returns to ON
    REQ = 4'b0000;
    repeat (3) step();
    REQ = 4'b0001;
    step();
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL rereq_early got=%0d exp=2", STATE); end
    REQ = 4'b0000;
    repeat (17) step();
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rereq_off got=%0d exp=0", STATE); end
  endtask

  task automatic test_test_mode();
    TE_IN = 1'b1;
    #1;
    checks++; if (TE !== 1'b1) begin errors++; $display("FAIL tm_te got=%0b exp=1", TE); end
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL tm_rdy got=%0b exp=1", RDY); end
    step();
    checks++; if (E !== 1'b0 || STATE !== 2'd0) begin errors++; $display("FAIL tm_fsm got E=%0b ST=%0d exp 0/0", E, STATE); end
    TE_IN = 1'b0;
    #1;
    checks++; if (RDY !== 1'b0 || TE !== 1'b0) begin errors++; $display("FAIL tm_off got RDY=%0b TE=%0b exp 0/0", RDY, TE); end
  endtask

  task automatic test_back_to_back();
    // Request dropped during WAKE: wake completes, then idles
    REQ = 4'b0001;
    step();
    REQ = 4'b0000;
    step();
    step();
    checks++; if (STATE !== 2'd2 || RDY !== 1'b1) begin
      errors++; $display("FAIL b2b_wake_done got ST=%0d RDY=%0b exp 2/1", STATE, RDY);
    end
    step();
    checks++; if (STATE !== 2'd3) begin errors++; $display("FAIL b2b_idle got=%0d exp=3", STATE); end
    repeat (16) step();
    checks++; if (STATE !== 2'd0 || E !== 1'b0) begin errors++; $display("FAIL b2b_off got ST=%0d E=%0b exp 0/0", STATE, E); end
  endtask

`ifdef CKGATE_CTRL_STATS_EN
  task automatic test_stats();
    STAT_CLR = 1'b1;
    step();
    STAT_CLR = 1'b0;
    checks++; if (WAKE_CNT !== 16'd0 || ON_CYC !== 32'd0) begin
      errors++; $display("FAIL st_clr got WAKE=%0d ON=%0d exp 0/0", WAKE_CNT, ON_CYC);
    end
    for (int n = 0; n < 2; n++) begin
      REQ = 4'b0001;
      repeat (5) step();
      REQ = 4'b0000;
      repeat (17) step();
    end
    checks++; if (WAKE_CNT !== 16'd2) begin errors++; $display("FAIL st_wake_cnt got=%0d exp=2", WAKE_CNT); end
    REQ = 4'b0001;
    repeat (4) step();
    STAT_CLR = 1'b1;
    step();
    STAT_CLR = 1'b0;
    checks++; if (ON_CYC !== 32'd0) begin errors++; $display("FAIL st_on_clr got=%0d exp=0", ON_CYC); end
    step();
    checks++; if (ON_CYC !== 32'd1) begin errors++; $display("FAIL st_on_count got=%0d exp=1", ON_CYC); end
    REQ = 4'b0000;
    repeat (17) step();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    RST    = 1'b1;
    TE_IN  = 1'b0;
    REQ    = 4'b0000;
`ifdef CKGATE_CTRL_STATS_EN
    STAT_CLR = 1'b0;
`endif
    #12;
    test_reset();
    test_wake();
    test_idle_timeout();
    test_rerequest();
    test_test_mode();
    test_back_to_back();
`ifdef CKGATE_CTRL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
